// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared FSM state encodings and default adder geometry for add_sched
package add_sched_pkg;
    localparam int CHUNK_DEF = 7;
    localparam int NCHUNK_DEF = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/add_sched_chunk_adder.sv
// chunk_adder: combinational W-bit ripple-carry adder of gate-level full adders; ports a, b, cin in, sum, cout out
module chunk_adder #(
    parameter int W = 7
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    logic [W-1:0] p, gen, t;
    assign c[0] = cin;
    for (genvar i = 0; i < W; i++) begin : fa
        xor (p[i], a[i], b[i]);
        xor (sum[i], p[i], c[i]);
        and (gen[i], a[i], b[i]);
        and (t[i], p[i], c[i]);
        or  (c[i+1], gen[i], t[i]);
    end
    assign cout = c[W];
endmodule

// File: rtl/add_sched.sv
// add_sched: two requesters share one CHUNK-bit adder, NCHUNK chunk adds per op; ports clk, rst, reqN_{valid,ready,a,b,cin}, rsp_{valid,ready,sum,cout,id}
module add_sched
    import add_sched_pkg::*;
#(
    parameter int CHUNK = CHUNK_DEF,
    parameter int NCHUNK = NCHUNK_DEF,
    localparam int W = CHUNK * NCHUNK,
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_id
);
    state_t state, next;
    logic [W-1:0] a, b;
    logic [CW-1:0] cnt;
    logic carry, last, go, grant_id, last_chunk, co;
    logic [CHUNK-1:0] ca, cb, s;
    always_comb begin
        go = state == IDLE && (req0_valid || req1_valid) && !rst;
        // on a tie the requester not served last wins; otherwise whoever is valid
        grant_id = req0_valid && req1_valid ? !last : req1_valid;
        req0_ready = go && !grant_id;
        req1_ready = go && grant_id;
        last_chunk = cnt == CW'(NCHUNK - 1);
        ca = a[cnt*CHUNK +: CHUNK];
        cb = b[cnt*CHUNK +: CHUNK];
        next = state == IDLE ? (go ? RUN : IDLE) :
               state == RUN  ? (last_chunk ? DONE : RUN) :
                               (rsp_ready ? IDLE : DONE);
        rsp_valid = state == DONE;
    end
    chunk_adder #(.W(CHUNK)) adder (.a(ca), .b(cb), .cin(carry), .sum(s), .cout(co));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            cnt <= '0;
            carry <= 1'b0;
            last <= 1'b1;
            rsp_sum <= '0;
            rsp_cout <= 1'b0;
            rsp_id <= 1'b0;
        end else begin
            state <= next;
            if (go) begin
                a <= grant_id ? req1_a : req0_a;
                b <= grant_id ? req1_b : req0_b;
                carry <= grant_id ? req1_cin : req0_cin;
                rsp_id <= grant_id;
                cnt <= '0;
            end
            if (state == RUN) begin
                rsp_sum[cnt*CHUNK +: CHUNK] <= s;
                carry <= co;
                cnt <= cnt + 1'b1;
                if (last_chunk) rsp_cout <= co;
            end
            if (state == DONE && rsp_ready) last <= rsp_id;
        end
    end
endmodule
